// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo
// Captures one retire event per completed instruction from the CPU core,
// buffers each as a record in a FIFO, and streams every record out as four
// 32-bit words over a valid/ready port.
//
// Ports:
//   clk, rst_n                      core clock, synchronous active-low reset
//   retire_valid/pc/inst            retire event from the core
//   rf_we/rf_waddr/rf_wdata         register-file write of the retiring instr
//   out_valid/out_ready/out_data    trace word stream
//   out_last                        marks word 3 (wdata) of each record
//   overflow, drop_count            sticky drop flag and saturating drop count
//   level                           records currently stored
//
// Serializer states:
//   state | meaning
//   IDLE  | no record being presented
//   W0    | presenting pc_off
//   W1    | presenting inst
//   W2    | presenting {we_eff, 00, waddr, seq, 00}
//   W3    | presenting wdata (out_last=1); handshake pops the head record
module retire_trace_fifo #(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] PC_BASE = 32'h00400000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     retire_valid,
  input  logic [31:0]              retire_pc,
  input  logic [31:0]              retire_inst,
  input  logic                     rf_we,
  input  logic [4:0]               rf_waddr,
  input  logic [31:0]              rf_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_inst  [DEPTH];
  logic [31:0]   r_mem_w2    [DEPTH];
  logic [31:0]   r_mem_wdata [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop_count;
  logic          r_overflow;
  state_t        r_state;
  logic          r_out_valid;
  logic [31:0]   r_out_data;
  logic          r_out_last;

  logic          w_we_eff;
  logic [31:0]   w_pc_off;
  logic [31:0]   w_w2;
  logic [31:0]   w_wdata;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_next;

  assign w_we_eff  = rf_we & (rf_waddr != 5'd0);
  assign w_pc_off  = retire_pc - PC_BASE;
  assign w_w2      = {w_we_eff, 2'b00, (w_we_eff ? rf_waddr : 5'd0), r_seq, 8'h00};
  assign w_wdata   = w_we_eff ? rf_wdata : 32'd0;
  // Fullness is judged on the registered level only, so a W3 pop in the
  // same cycle never frees a slot for a push into a full FIFO.
  assign w_push    = retire_valid & (r_level < LW'(DEPTH));
  assign w_pop     = (r_state == W3) & out_ready;
  assign w_rd_next = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem_pc[r_wr_ptr]    <= w_pc_off;
      r_mem_inst[r_wr_ptr]  <= retire_inst;
      r_mem_w2[r_wr_ptr]    <= w_w2;
      r_mem_wdata[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_seq        <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_state      <= IDLE;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      // Dropped events still consume a sequence number so gaps expose them.
      if (retire_valid) r_seq <= r_seq + 16'd1;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);

      if (retire_valid && !w_push) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end

      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);

      case (r_state)
        IDLE: begin
          if (r_level != '0) begin
            r_state     <= W0;
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem_pc[r_rd_ptr];
            r_out_last  <= 1'b0;
          end
        end
        W0: begin
          if (out_ready) begin
            r_state    <= W1;
            r_out_data <= r_mem_inst[r_rd_ptr];
          end
        end
        W1: begin
          if (out_ready) begin
            r_state    <= W2;
            r_out_data <= r_mem_w2[r_rd_ptr];
          end
        end
        W2: begin
          if (out_ready) begin
            r_state    <= W3;
            r_out_data <= r_mem_wdata[r_rd_ptr];
            r_out_last <= 1'b1;
          end
        end
        W3: begin
          if (out_ready) begin
            r_rd_ptr   <= w_rd_next;
            r_out_last <= 1'b0;
            if (r_level > LW'(1)) begin
              r_state    <= W0;
              r_out_data <= r_mem_pc[w_rd_next];
            end else if (w_push) begin
              // The only remaining record is being written this very edge,
              // so take W0 straight from the input to avoid an idle cycle.
              r_state    <= W0;
              r_out_data <= w_pc_off;
            end else begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign level      = r_level;

endmodule

// File: tb/tb_retire_trace_fifo.sv
module tb_retire_trace_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_inst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [15:0] drop_count;
  logic [4:0]  level;

  always #5 clk = ~clk;

  retire_trace_fifo #(.DEPTH(16), .PC_BASE(32'h00400000)) dut (
    .clk(clk), .rst_n(rst_n),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .overflow(overflow), .drop_count(drop_count), .level(level)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  vec_t  vecs[5];
  word_t exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  int    seq_m  = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    exp_q.push_back(w);
  endtask

  // Reference model of one record's four output words.
  task automatic exp_rec(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic [15:0] sq);
    logic we_eff;
    we_eff = we && (wa != 5'd0);
    push_word(pc - 32'h00400000, 1'b0);
    push_word(inst, 1'b0);
    push_word({we_eff, 2'b00, (we_eff ? wa : 5'd0), sq, 8'h00}, 1'b0);
    push_word(we_eff ? wd : 32'd0, 1'b1);
  endtask

  task automatic pulse(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    retire_pc    = pc;
    retire_inst  = inst;
    rf_we        = we;
    rf_waddr     = wa;
    rf_wdata     = wd;
    retire_valid = 1'b1;
  endtask

  task automatic record(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input bit keep);
    if (keep) exp_rec(pc, inst, we, wa, wd, seq_m[15:0]);
    pulse(pc, inst, we, wa, wd);
    seq_m++;
  endtask

  task automatic drain(input int nwords, input bit rnd, output int cycles);
    int          got;
    int          cyc;
    bit          stalled;
    bit          r;
    logic [31:0] pd;
    logic        pl;
    word_t       e;
    got = 0; cyc = 0; stalled = 0; pd = '0; pl = 1'b0;
    while (got < nwords && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (stalled)
        check(out_valid === 1'b1 && out_data === pd && out_last === pl, "stall_hold",
              {31'd0, out_last, out_data}, {31'd0, pl, pd});
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      stalled = 0;
      if (out_valid === 1'b1) begin
        if (r) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "extra_word", {31'd0, out_last, out_data}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check(out_data === e.d && out_last === e.l, "word",
                  {31'd0, out_last, out_data}, {31'd0, e.l, e.d});
          end
          got++;
        end else begin
          stalled = 1;
          pd = out_data;
          pl = out_last;
        end
      end
    end
    if (got < nwords) check(1'b0, "drain_timeout", 64'(got), 64'(nwords));
    cycles = cyc;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc;
    word_t e;

    vecs[0] = '{32'h00400004, 32'h20010005, 1'b1, 5'd1,  32'h00000005,
                32'h00000004, 32'h20010005, 32'h81000000, 32'h00000005};
    vecs[1] = '{32'h00400008, 32'h2000FFFF, 1'b1, 5'd0,  32'hFFFFFFFF,
                32'h00000008, 32'h2000FFFF, 32'h00000100, 32'h00000000};
    vecs[2] = '{32'h003FFFFC, 32'h00000000, 1'b0, 5'd5,  32'h12345678,
                32'hFFFFFFFC, 32'h00000000, 32'h00000200, 32'h00000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hAC220010, 1'b1, 5'd31, 32'hDEADBEEF,
                32'hFFBFFFFF, 32'hAC220010, 32'h9F000300, 32'hDEADBEEF};
    vecs[4] = '{32'h00400000, 32'h8C0A0004, 1'b1, 5'd10, 32'h00000000,
                32'h00000000, 32'h8C0A0004, 32'h8A000400, 32'h00000000};

    rst_n = 1'b0; retire_valid = 1'b0; retire_pc = '0; retire_inst = '0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a record being streamed, with a retire pending.
    out_ready = 1'b1;
    pulse(32'h00400100, 32'h12345678, 1'b1, 5'd3, 32'hAAAA5555);
    @(negedge clk); retire_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; retire_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check(out_valid === 1'b0 && out_data === 32'd0 && out_last === 1'b0 && overflow === 1'b0 &&
            drop_count === 16'd0 && level === 5'd0, "reset_outputs",
            {out_valid, out_last, overflow, level, drop_count, out_data}, 64'd0);
    end
    rst_n = 1'b1; retire_valid = 1'b0;
    seq_m = 0;
    exp_q.delete();

    // Single records, hand-computed words.
    for (int i = 0; i < 5; i++) begin
      push_word(vecs[i].w0, 1'b0);
      push_word(vecs[i].w1, 1'b0);
      push_word(vecs[i].w2, 1'b0);
      push_word(vecs[i].w3, 1'b1);
      pulse(vecs[i].pc, vecs[i].inst, vecs[i].we, vecs[i].wa, vecs[i].wd);
      seq_m++;
      @(negedge clk); retire_valid = 1'b0;
      drain(4, 1'b0, cyc);
    end
    repeat (3) @(negedge clk);
    check(out_valid === 1'b0 && level === 5'd0, "no_replay", {out_valid, level}, 64'd0);

    // Backpressure: queued records drained with random ready.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      record(32'h00400200 + 32'(4 * i), 32'h8C000000 | 32'(i), (i != 2),
             5'(i * 7), 32'h00001000 + 32'(i), 1'b1);
    @(negedge clk); retire_valid = 1'b0;
    drain(20, 1'b1, cyc);

    // Back-to-back burst then steady stream; pointers wrap more than twice.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          record(32'h00401000 + 32'(4 * i), {16'hABCD, 16'(i)}, i[0], 5'(i), ~32'(i), 1'b1);
          if (i >= 16) begin
            @(negedge clk); retire_valid = 1'b0;
            repeat (2) @(negedge clk);
          end
        end
        @(negedge clk); retire_valid = 1'b0;
      end
      begin
        drain(160, 1'b0, cyc);
      end
    join
    check(drop_count === 16'd0 && overflow === 1'b0, "stream_no_drop",
          {overflow, drop_count}, 64'd0);
    check(exp_q.size() == 0, "stream_all_seen", 64'(exp_q.size()), 64'd0);

    // Overflow with a push coinciding with a W3 pop on a full FIFO.
    @(negedge clk); rst_n = 1'b0; out_ready = 1'b0; retire_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    seq_m = 0;
    exp_q.delete();
    for (int i = 0; i < 18; i++)
      record(32'h00402000 + 32'(4 * i), 32'h01000000 + 32'(i), 1'b1, 5'(i + 1), 32'(i * 3), (i < 16));
    @(negedge clk); retire_valid = 1'b0;
    check(level === 5'd16, "full_level", 64'(level), 64'd16);
    check(overflow === 1'b1, "overflow_set", 64'(overflow), 64'd1);
    check(drop_count === 16'd2, "drop_count_2", 64'(drop_count), 64'd2);
    for (int w = 0; w < 4; w++) begin
      if (w > 0) @(negedge clk);
      e = exp_q.pop_front();
      check(out_valid === 1'b1 && out_data === e.d && out_last === e.l, "first_rec",
            {31'd0, out_last, out_data}, {31'd0, e.l, e.d});
      out_ready = 1'b1;
      if (w == 3) begin
        retire_valid = 1'b1;
        seq_m++;
      end
    end
    @(negedge clk); retire_valid = 1'b0; out_ready = 1'b0;
    check(drop_count === 16'd3, "drop_on_pop", 64'(drop_count), 64'd3);
    check(level === 5'd15, "level_after_pop", 64'(level), 64'd15);
    check(out_valid === 1'b1 && out_last === 1'b0, "no_gap_w0", {out_valid, out_last}, 64'h2);
    drain(60, 1'b0, cyc);
    check(cyc == 60, "throughput", 64'(cyc), 64'd60);

    // Long run: sequence wrap and drop-count saturation.
    @(negedge clk); rst_n = 1'b0; out_ready = 1'b0; retire_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    seq_m = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      record(32'h00403000 + 32'(4 * i), 32'h02000000 + 32'(i), 1'b1, 5'd7, 32'(i), 1'b1);
    repeat (65537) @(negedge clk);
    retire_valid = 1'b0;
    seq_m = seq_m + 65536;
    check(drop_count === 16'hFFFF, "drop_saturate", 64'(drop_count), 64'hFFFF);
    check(level === 5'd16, "long_level", 64'(level), 64'd16);
    drain(64, 1'b0, cyc);
    record(32'h00404000, 32'h03000000, 1'b1, 5'd9, 32'h0BADF00D, 1'b1);
    @(negedge clk); retire_valid = 1'b0;
    drain(4, 1'b0, cyc);
    check(drop_count === 16'hFFFF, "drop_hold", 64'(drop_count), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
